// File: rtl/tone_decoder.sv
// Tone decoder: measures the period of a square-wave note input and confirms one
// of eight nominal notes after two consecutive matching periods.
module tone_decoder #(
    parameter int               TOL     = 1024,
    parameter int               TIMEOUT = 262143,
    parameter logic [7:0][17:0] NOMINAL = {18'd95602,  18'd101418, 18'd113636, 18'd127552,
                                           18'd143266, 18'd151974, 18'd170648, 18'd191570}
) (
    input  logic        clk1,
    input  logic        reset,
    input  logic        tone_in,
    output logic [2:0]  note,
    output logic        note_valid,
    output logic        note_strb,
    output logic [7:0]  note_onehot,
    output logic [17:0] period,
    output logic        state_dbg
);

    localparam logic [17:0] TIMEOUT_C = 18'(TIMEOUT);
    localparam logic [17:0] TOL_C     = 18'(TOL);

    typedef enum logic {
        IDLE    = 1'b0,
        MEASURE = 1'b1
    } state_t;

    state_t      state_q, state_d;
    logic        sync1_q, sync1_d;
    logic        sync2_q, sync2_d;
    logic        hist_q, hist_d;
    logic [17:0] cnt_q, cnt_d;
    logic [17:0] period_q, period_d;
    logic [2:0]  cand_q, cand_d;
    logic [1:0]  streak_q, streak_d;
    logic [2:0]  note_q, note_d;
    logic        valid_q, valid_d;
    logic        strb_q, strb_d;

    logic        edge_p;
    logic        capture;
    logic        timeout;
    logic [17:0] meas;
    logic        hit;
    logic [2:0]  hit_idx;
    logic [17:0] diff;

    assign edge_p = sync2_q & ~hist_q;
    assign meas   = cnt_q + 18'd1;

    // Windows are disjoint, so at most one index can hit.
    always_comb begin
        hit     = 1'b0;
        hit_idx = 3'd0;
        diff    = 18'd0;
        for (int k = 0; k < 8; k++) begin
            if (meas >= NOMINAL[k]) diff = meas - NOMINAL[k];
            else                    diff = NOMINAL[k] - meas;
            if (diff <= TOL_C) begin
                hit     = 1'b1;
                hit_idx = k[2:0];
            end
        end
    end

    always_comb begin
        sync1_d  = tone_in;
        sync2_d  = sync1_q;
        hist_d   = sync2_q;
        state_d  = state_q;
        cnt_d    = cnt_q;
        period_d = period_q;
        cand_d   = cand_q;
        streak_d = streak_q;
        capture  = 1'b0;
        timeout  = 1'b0;

        case (state_q)
            IDLE: begin
                cnt_d = 18'd0;
                if (edge_p) state_d = MEASURE;
            end
            MEASURE: begin
                // An edge on the TIMEOUT count is still a valid period.
                if (edge_p) begin
                    capture  = 1'b1;
                    period_d = meas;
                    cnt_d    = 18'd0;
                end else if (cnt_q == TIMEOUT_C) begin
                    timeout  = 1'b1;
                    state_d  = IDLE;
                    cnt_d    = 18'd0;
                    cand_d   = 3'd0;
                    streak_d = 2'd0;
                end else begin
                    cnt_d = meas;
                end
            end
            default: state_d = IDLE;
        endcase

        if (capture) begin
            if (!hit) begin
                cand_d   = 3'd0;
                streak_d = 2'd0;
            end else if (hit_idx == cand_q) begin
                if (streak_q != 2'd2) streak_d = streak_q + 2'd1;
            end else begin
                cand_d   = hit_idx;
                streak_d = 2'd1;
            end
        end

        // Output stage trails the streak by one cycle.
        valid_d = (streak_q == 2'd2) && !timeout;
        note_d  = valid_d ? cand_q : note_q;
        strb_d  = valid_d && !valid_q;
    end

    always_ff @(posedge clk1) begin
        if (reset) begin
            sync1_q  <= 1'b0;
            sync2_q  <= 1'b0;
            hist_q   <= 1'b0;
            state_q  <= IDLE;
            cnt_q    <= 18'd0;
            period_q <= 18'd0;
            cand_q   <= 3'd0;
            streak_q <= 2'd0;
            note_q   <= 3'd0;
            valid_q  <= 1'b0;
            strb_q   <= 1'b0;
        end else begin
            sync1_q  <= sync1_d;
            sync2_q  <= sync2_d;
            hist_q   <= hist_d;
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            period_q <= period_d;
            cand_q   <= cand_d;
            streak_q <= streak_d;
            note_q   <= note_d;
            valid_q  <= valid_d;
            strb_q   <= strb_d;
        end
    end

    assign note        = note_q;
    assign note_valid  = valid_q;
    assign note_strb   = strb_q;
    assign note_onehot = valid_q ? (8'd1 << note_q) : 8'd0;
    assign period      = period_q;
    assign state_dbg   = (state_q == MEASURE);

endmodule

// File: tb/tb_tone_decoder.sv
// Directed bench for tone_decoder with nominal periods scaled down by 100 so every
// scenario fits a short run; strobes are checked against an expected queue.
module tb_tone_decoder;

    localparam int TOL     = 20;
    localparam int TIMEOUT = 2500;
    localparam logic [7:0][17:0] NOM = {18'd956,  18'd1014, 18'd1136, 18'd1275,
                                        18'd1432, 18'd1519, 18'd1706, 18'd1915};
    localparam int W = 35;

    logic        clk1 = 1'b0;
    logic        reset;
    logic        tone_in;
    logic [2:0]  note;
    logic        note_valid;
    logic        note_strb;
    logic [7:0]  note_onehot;
    logic [17:0] period;
    logic        state_dbg;

    int n_checks  = 0;
    int n_fail    = 0;
    int cyc       = 0;
    int last_edge = 0;
    int c_edge;
    logic [W-1:0] exp_q[$];
    logic [W-1:0] exp_e;

    tone_decoder #(
        .TOL     (TOL),
        .TIMEOUT (TIMEOUT),
        .NOMINAL (NOM)
    ) dut (
        .clk1        (clk1),
        .reset       (reset),
        .tone_in     (tone_in),
        .note        (note),
        .note_valid  (note_valid),
        .note_strb   (note_strb),
        .note_onehot (note_onehot),
        .period      (period),
        .state_dbg   (state_dbg)
    );

    // Clock and cycle count.
    always #5 clk1 = ~clk1;
    always @(posedge clk1) cyc <= cyc + 1;

    initial begin
        #(1_000_000);
        $display("FAIL watchdog: observed no end of test by %0t, required finish", $time);
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clk1);
    endtask

    task automatic do_reset(input logic tone_level);
        tone_in = tone_level;
        reset   = 1'b1;
        wait_cycles(2);
        reset   = 1'b0;
    endtask

    // One rising edge followed by p cycles of tone; a strobe is expected four
    // cycles after the drive (2 sync flops, capture, output register).
    task automatic tone_period(input int p, input int strobe_note);
        tone_in   = 1'b1;
        last_edge = cyc;
        if (strobe_note >= 0) exp_q.push_back({3'(strobe_note), 32'(cyc + 4)});
        wait_cycles(p / 2);
        tone_in = 1'b0;
        wait_cycles(p - p / 2);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_note"},   32'(note), 0);
        check({tag, "_valid"},  32'(note_valid), 0);
        check({tag, "_strb"},   32'(note_strb), 0);
        check({tag, "_onehot"}, 32'(note_onehot), 0);
        check({tag, "_period"}, 32'(period), 0);
        check({tag, "_state"},  32'(state_dbg), 0);
    endtask

    // Scoreboard: every strobe must match the head of the expected queue.
    always @(negedge clk1) begin
        if (note_strb === 1'b1) begin
            n_checks++;
            assert (exp_q.size() > 0) else begin
                n_fail++;
                $error("FAIL strobe_unexpected: observed strobe note %0d at cycle %0d, expected none", note, cyc);
            end
            if (exp_q.size() > 0) begin
                exp_e = exp_q.pop_front();
                check("strobe_note",   32'(note), 32'(exp_e[34:32]));
                check("strobe_cycle",  32'(cyc), exp_e[31:0]);
                check("strobe_valid",  32'(note_valid), 1);
                check("strobe_onehot", 32'(note_onehot), 32'(8'd1 << exp_e[34:32]));
            end
        end
    end

    initial begin
        reset   = 1'b1;
        tone_in = 1'b0;
        @(negedge clk1);
        do_reset(1'b0);
        check_all_zero("reset");

        // Note 5 locks on the third rising edge and stays without a second strobe.
        do_reset(1'b0);
        tone_period(1136, -1);
        tone_period(1136, -1);
        check("a_valid_early", 32'(note_valid), 0);
        tone_period(1136, 5);
        check("a_period", 32'(period), 1136);
        check("a_note",   32'(note), 5);
        check("a_valid",  32'(note_valid), 1);
        check("a_onehot", 32'(note_onehot), 32'h20);
        tone_period(1136, -1);
        check("a_hold_valid", 32'(note_valid), 1);
        check("a_hold_note",  32'(note), 5);

        // Switch from note 0 to note 7.
        do_reset(1'b0);
        tone_period(1915, -1);
        tone_period(1915, -1);
        tone_period(956, 0);
        check("b_note0",  32'(note), 0);
        check("b_valid0", 32'(note_valid), 1);
        check("b_period0", 32'(period), 1915);
        tone_period(956, -1);
        check("b_drop_valid", 32'(note_valid), 0);
        check("b_drop_note",  32'(note), 0);
        check("b_drop_period", 32'(period), 956);
        tone_period(956, 7);
        check("b_note7",   32'(note), 7);
        check("b_valid7",  32'(note_valid), 1);
        check("b_onehot7", 32'(note_onehot), 32'h80);

        // Period between two windows never validates.
        do_reset(1'b0);
        repeat (4) tone_period(1350, -1);
        check("c_valid",  32'(note_valid), 0);
        check("c_period", 32'(period), 1350);
        check("c_onehot", 32'(note_onehot), 0);

        // Tolerance boundaries around note 4: +TOL matches, -(TOL+1) does not.
        do_reset(1'b0);
        tone_period(1295, -1);
        tone_period(1295, -1);
        tone_period(1254, 4);
        check("d_valid_hi", 32'(note_valid), 1);
        check("d_note_hi",  32'(note), 4);
        tone_period(1295, -1);
        check("d_unmatched_valid",  32'(note_valid), 0);
        check("d_unmatched_note",   32'(note), 4);
        check("d_unmatched_period", 32'(period), 1254);
        tone_period(1295, -1);
        check("d_restart_valid", 32'(note_valid), 0);
        tone_period(1295, 4);
        check("d_relock_valid", 32'(note_valid), 1);

        // Timeout: counter restarts 3 cycles after the drive, reaches TIMEOUT
        // TIMEOUT cycles later, and valid clears on the following clock.
        do_reset(1'b0);
        tone_period(1519, -1);
        tone_period(1519, -1);
        tone_period(1519, 2);
        c_edge = last_edge;
        while (cyc < c_edge + 3 + TIMEOUT) @(negedge clk1);
        check("e_valid_before", 32'(note_valid), 1);
        check("e_state_before", 32'(state_dbg), 1);
        @(negedge clk1);
        check("e_valid_after",  32'(note_valid), 0);
        check("e_note_after",   32'(note), 2);
        check("e_state_after",  32'(state_dbg), 0);
        check("e_period_after", 32'(period), 1519);

        // Edge exactly at the TIMEOUT count is a capture; one cycle later it is lost.
        do_reset(1'b0);
        tone_period(TIMEOUT + 1, -1);
        tone_period(TIMEOUT + 2, -1);
        check("f_coincident_period", 32'(period), TIMEOUT + 1);
        check("f_coincident_state",  32'(state_dbg), 1);
        tone_period(1136, -1);
        check("f_late_period", 32'(period), TIMEOUT + 1);
        check("f_late_state",  32'(state_dbg), 1);
        tone_period(1136, -1);
        check("f_rearm_period", 32'(period), 1136);

        // Reset mid-period clears everything; relock needs three new edges.
        do_reset(1'b0);
        tone_period(1432, -1);
        tone_period(1432, -1);
        tone_period(1432, 3);
        check("g_locked_note", 32'(note), 3);
        wait_cycles(200);
        reset = 1'b1;
        wait_cycles(1);
        reset = 1'b0;
        check_all_zero("g_reset");
        tone_period(1432, -1);
        tone_period(1432, -1);
        check("g_relock_early", 32'(note_valid), 0);
        check("g_relock_period", 32'(period), 1432);
        tone_period(1432, 3);
        check("g_relock_valid", 32'(note_valid), 1);
        check("g_relock_note",  32'(note), 3);

        // Tone high through reset release only arms the measurement.
        do_reset(1'b1);
        wait_cycles(10);
        check("h_state",  32'(state_dbg), 1);
        check("h_period", 32'(period), 0);
        check("h_valid",  32'(note_valid), 0);
        tone_in = 1'b0;
        wait_cycles(20);

        check("strobes_pending", 32'(exp_q.size()), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
